// File: rtl/matrix_scroll_ctrl.sv
// Row-scan and frame-aligned column-shift sequencer for an 8x8 LED matrix.
// Optional SCROLL_BOUNCE_EN: direction ping-pongs on every message wrap.
module matrix_scroll_ctrl #(
  parameter int SCAN_DIV_EXP  = 12,
  parameter int SHIFT_DIV_EXP = 20,
  parameter int MSG_COLS      = 72,
  parameter int HOLD_FRAMES   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       enable,
  input  logic       selrl,
  output logic [7:0] row,
  output logic [2:0] cnt,
  output logic       shift_en,
  output logic       shift_dir,
  output logic [6:0] col_pos,
  output logic       wrap,
  output logic       busy
);

  localparam int HCW =
    (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [6:0] LAST = 7'(MSG_COLS - 1);
  localparam logic [HCW-1:0] HLAST =
    HCW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE, RUN, PAUSE, HOLD
  } state_e;

  state_e state_q, state_d;

  logic [SCAN_DIV_EXP-1:0]  scan_div_q;
  logic [SHIFT_DIV_EXP-1:0] shift_div_q, shift_div_d;
  logic [7:0]     row_q;
  logic [2:0]     cnt_q;
  logic [6:0]     col_q, col_d, nxt_col;
  logic [HCW-1:0] hold_q, hold_d;
  logic pend_q, pend_d;
  logic dir_q, dir_d;
  logic sen_q, sen_d;
  logic sdir_q, sdir_d;
  logic wrap_q, wrap_d;
  logic scan_tick, frame_end, shift_req;

  assign scan_tick = &scan_div_q;
  assign frame_end = scan_tick && (cnt_q == 3'd7);
  assign shift_req = (state_q == RUN) && (&shift_div_q);

  always_comb begin
    nxt_col = col_q;
    if (dir_q)
      nxt_col = (col_q == LAST) ? 7'd0 : col_q + 7'd1;
    else
      nxt_col = (col_q == 7'd0) ? LAST : col_q - 7'd1;
  end

  always_comb begin
    state_d     = state_q;
    shift_div_d = shift_div_q;
    pend_d      = pend_q;
    hold_d      = hold_q;
    col_d       = col_q;
    dir_d       = dir_q;
    sen_d       = 1'b0;
    sdir_d      = sdir_q;
    wrap_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        shift_div_d = '0;
        pend_d      = 1'b0;
        hold_d      = '0;
        if (start) begin
          state_d = RUN;
`ifdef SCROLL_BOUNCE_EN
          dir_d = selrl;
`endif
        end
      end
      RUN: begin
        shift_div_d = shift_div_q + 1'b1;
        if (shift_req) pend_d = 1'b1;
        if (!enable) begin
          state_d = PAUSE;
        end else if (frame_end && pend_q) begin
          // a request landing on the service edge survives
          pend_d = shift_req;
          sen_d  = 1'b1;
          sdir_d = dir_q;
          col_d  = nxt_col;
          if (nxt_col == 7'd0) begin
            wrap_d = 1'b1;
            if (HOLD_FRAMES > 0) state_d = HOLD;
          end
        end
      end
      PAUSE: begin
        if (enable) state_d = RUN;
      end
      HOLD: begin
        shift_div_d = '0;
        if (frame_end) begin
          if (hold_q == HLAST) begin
            state_d = RUN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
    endcase
`ifdef SCROLL_BOUNCE_EN
    if (wrap_d) dir_d = ~dir_q;
`else
    if (frame_end) dir_d = selrl;
`endif
    if (stop) begin
      state_d     = IDLE;
      shift_div_d = '0;
      pend_d      = 1'b0;
      hold_d      = '0;
      col_d       = col_q;
      sen_d       = 1'b0;
      sdir_d      = sdir_q;
      wrap_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      scan_div_q  <= '0;
      shift_div_q <= '0;
      row_q       <= 8'b0000_0001;
      cnt_q       <= 3'd0;
      col_q       <= 7'd0;
      hold_q      <= '0;
      pend_q      <= 1'b0;
      dir_q       <= 1'b1;
      sen_q       <= 1'b0;
      sdir_q      <= 1'b1;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_div_q  <= scan_div_q + 1'b1;
      shift_div_q <= shift_div_d;
      if (scan_tick) begin
        row_q <= {row_q[0], row_q[7:1]};
        cnt_q <= cnt_q + 3'd1;
      end
      col_q  <= col_d;
      hold_q <= hold_d;
      pend_q <= pend_d;
      dir_q  <= dir_d;
      sen_q  <= sen_d;
      sdir_q <= sdir_d;
      wrap_q <= wrap_d;
    end
  end

  assign row       = row_q;
  assign cnt       = cnt_q;
  assign shift_en  = sen_q;
  assign shift_dir = sdir_q;
  assign col_pos   = col_q;
  assign wrap      = wrap_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_matrix_scroll_ctrl.sv
// Directed bench for matrix_scroll_ctrl with small dividers.
// Covers scan, stepping, wrap/hold, pause, stop and reset.
module tb_matrix_scroll_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       enable = 1'b0;
  logic       selrl = 1'b1;
  logic [7:0] row;
  logic [2:0] cnt;
  logic       shift_en, shift_dir, wrap, busy;
  logic [6:0] col_pos;

  int n_chk = 0;
  int n_err = 0;

  matrix_scroll_ctrl #(
    .SCAN_DIV_EXP (2),
    .SHIFT_DIV_EXP(5),
    .MSG_COLS     (9),
    .HOLD_FRAMES  (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .enable   (enable),
    .selrl    (selrl),
    .row      (row),
    .cnt      (cnt),
    .shift_en (shift_en),
    .shift_dir(shift_dir),
    .col_pos  (col_pos),
    .wrap     (wrap),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic wait_shift(input int budget,
                            output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (shift_en !== 1'b1 && cyc < budget);
    chk("shift_seen", 32'(shift_en), 32'd1);
  endtask

  task automatic shift_expect(input string tag,
                              input int budget,
                              input logic [6:0] c,
                              input logic d,
                              input logic w);
    int cyc;
    wait_shift(budget, cyc);
    chk({tag, "_col"}, 32'(col_pos), 32'(c));
    chk({tag, "_dir"}, 32'(shift_dir), 32'(d));
    chk({tag, "_wrap"}, 32'(wrap), 32'(w));
    chk({tag, "_cnt"}, 32'(cnt), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_row"}, 32'(row), 32'h01);
    chk({tag, "_cnt"}, 32'(cnt), 32'd0);
    chk({tag, "_sen"}, 32'(shift_en), 32'd0);
    chk({tag, "_sdir"}, 32'(shift_dir), 32'd1);
    chk({tag, "_col"}, 32'(col_pos), 32'd0);
    chk({tag, "_wrap"}, 32'(wrap), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [7:0] row_tab [8] = '{
    8'h80, 8'h40, 8'h20, 8'h10,
    8'h08, 8'h04, 8'h02, 8'h01
  };

  initial begin
    int cyc;
    int n_sh;
    int n_rc;
    logic [7:0] prev;

    // scan only, held idle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("rst");
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      chk("scan_row", 32'(row), 32'(row_tab[i]));
      chk("scan_cnt", 32'(cnt), 32'((i + 1) % 8));
      chk("idle_sen", 32'(shift_en), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // run left
    start  = 1'b1;
    enable = 1'b1;
    selrl  = 1'b1;
    wait_shift(80, cyc);
    chk("first_lat", 32'(cyc >= 32), 32'd1);
    chk("first_col", 32'(col_pos), 32'd1);
    chk("first_dir", 32'(shift_dir), 32'd1);
    chk("first_cnt", 32'(cnt), 32'd0);
    @(negedge clk);
    chk("pulse_sen", 32'(shift_en), 32'd0);
    for (int c = 2; c <= 8; c++)
      shift_expect("left", 80, 7'(c), 1'b1, 1'b0);
    shift_expect("wrapL", 80, 7'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("pulse_wrap", 32'(wrap), 32'd0);

    // dwell
    n_sh = 0;
    repeat (63) begin
      @(negedge clk);
      if (shift_en) n_sh++;
    end
    chk("hold_noshift", 32'(n_sh), 32'd0);
    chk("hold_busy", 32'(busy), 32'd1);

`ifdef SCROLL_BOUNCE_EN
    selrl = 1'b1;
    shift_expect("bnc0", 100, 7'd8, 1'b0, 1'b0);
    shift_expect("bnc1", 80, 7'd7, 1'b0, 1'b0);
`else
    shift_expect("resume", 100, 7'd1, 1'b1, 1'b0);
    shift_expect("l2", 80, 7'd2, 1'b1, 1'b0);
    shift_expect("l3", 80, 7'd3, 1'b1, 1'b0);
    // toggled mid-frame: old direction once more
    selrl = 1'b0;
    shift_expect("old_dir", 80, 7'd4, 1'b1, 1'b0);
    shift_expect("r3", 80, 7'd3, 1'b0, 1'b0);
    shift_expect("r2", 80, 7'd2, 1'b0, 1'b0);

    // pause
    enable = 1'b0;
    n_sh = 0;
    n_rc = 0;
    prev = row;
    repeat (200) begin
      @(negedge clk);
      if (shift_en) n_sh++;
      if (row != prev) n_rc++;
      prev = row;
    end
    chk("pause_noshift", 32'(n_sh), 32'd0);
    chk("pause_col", 32'(col_pos), 32'd2);
    chk("pause_scan", 32'(n_rc), 32'd50);
    chk("pause_busy", 32'(busy), 32'd1);
    enable = 1'b1;
    shift_expect("unpause", 40, 7'd1, 1'b0, 1'b0);
    shift_expect("wrapR", 80, 7'd0, 1'b0, 1'b1);

    // stop beats start inside the dwell
    stop = 1'b1;
    @(negedge clk);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_col", 32'(col_pos), 32'd0);
    selrl = 1'b1;
    stop  = 1'b0;
    shift_expect("rs1", 80, 7'd1, 1'b1, 1'b0);
    shift_expect("rs2", 80, 7'd2, 1'b1, 1'b0);
    stop = 1'b1;
    @(negedge clk);
    chk("stop2_busy", 32'(busy), 32'd0);
    n_sh = 0;
    repeat (80) begin
      @(negedge clk);
      if (shift_en) n_sh++;
    end
    chk("stop2_noshift", 32'(n_sh), 32'd0);
    chk("stop2_col", 32'(col_pos), 32'd2);
    stop = 1'b0;
`endif

    // reset mid-run
    repeat (40) @(negedge clk);
    chk("prerst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst2");
    reset = 1'b0;
    n_sh = 0;
    repeat (100) begin
      @(negedge clk);
      if (shift_en) n_sh++;
    end
    chk("rst2_noshift", 32'(n_sh), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
